// File: rtl/mem_stage_pkg.sv
// Shared core definitions for the memory stage: widths, mem_op and exception codes, FSM states.
// Also provides the MEM/WB register layout and the op classification helpers.
package mem_stage_pkg;

    localparam int WORD_W     = 32;
    localparam int REG_ADDR_W = 5;
    localparam int MEM_OP_W   = 4;
    localparam int EXP_CODE_W = 4;
    localparam int HART_ST_W  = 2;

    typedef enum logic [MEM_OP_W-1:0] {
        MEM_OP_NOP = 4'd0,
        MEM_OP_LB  = 4'd1,
        MEM_OP_LH  = 4'd2,
        MEM_OP_LW  = 4'd3,
        MEM_OP_LBU = 4'd4,
        MEM_OP_LHU = 4'd5,
        MEM_OP_SB  = 4'd6,
        MEM_OP_SH  = 4'd7,
        MEM_OP_SW  = 4'd8
    } mem_op_e;

    localparam logic [EXP_CODE_W-1:0] EXP_NONE           = 4'd0;
    localparam logic [EXP_CODE_W-1:0] EXP_LOAD_MISALIGN  = 4'd4;
    localparam logic [EXP_CODE_W-1:0] EXP_STORE_MISALIGN = 4'd6;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } mem_state_e;

    typedef struct packed {
        logic                  en;
        logic [WORD_W-1:0]     pc;
        logic [EXP_CODE_W-1:0] exp_code;
        logic [REG_ADDR_W-1:0] rd_addr;
        logic                  gpr_we_;
        logic [WORD_W-1:0]     out;
        logic [HART_ST_W-1:0]  hart_st;
    } mem_wb_t;

    localparam mem_wb_t WB_BUBBLE = '{en: 1'b0, pc: '0, exp_code: '0, rd_addr: '0,
                                      gpr_we_: 1'b1, out: '0, hart_st: '0};

    function automatic logic is_load(input logic [MEM_OP_W-1:0] op);
        return (op == MEM_OP_LB) || (op == MEM_OP_LH) || (op == MEM_OP_LW) ||
               (op == MEM_OP_LBU) || (op == MEM_OP_LHU);
    endfunction

    function automatic logic is_store(input logic [MEM_OP_W-1:0] op);
        return (op == MEM_OP_SB) || (op == MEM_OP_SH) || (op == MEM_OP_SW);
    endfunction

    function automatic logic misaligned(input logic [MEM_OP_W-1:0] op, input logic [1:0] lo);
        logic half_op;
        logic word_op;
        half_op = (op == MEM_OP_LH) || (op == MEM_OP_LHU) || (op == MEM_OP_SH);
        word_op = (op == MEM_OP_LW) || (op == MEM_OP_SW);
        return (half_op && lo[0]) || (word_op && (lo != 2'b00));
    endfunction

endpackage

// File: rtl/mem_align.sv
// Byte-lane steering: store byte enables/lane replication and load lane extraction/extension.
// Latency: purely combinational.
// Backpressure: none; follows its inputs.
module mem_align
    import mem_stage_pkg::*;
(
    input  logic [MEM_OP_W-1:0] mem_op,
    input  logic [1:0]          addr_lo,
    input  logic [WORD_W-1:0]   st_data,
    input  logic [WORD_W-1:0]   ld_raw,
    output logic [3:0]          be,
    output logic [WORD_W-1:0]   st_lanes,
    output logic [WORD_W-1:0]   ld_data
);

    logic [WORD_W-1:0] byte_w;
    logic [15:0]       half_w;

    // Little-endian: the addressed byte is shifted down to bits [7:0].
    assign byte_w = ld_raw >> {addr_lo, 3'b000};
    assign half_w = addr_lo[1] ? ld_raw[31:16] : ld_raw[15:0];

    always_comb begin
        be       = 4'b0000;
        st_lanes = '0;
        ld_data  = '0;
        case (mem_op)
            MEM_OP_SB: begin
                be       = 4'b0001 << addr_lo;
                st_lanes = {4{st_data[7:0]}};
            end
            MEM_OP_SH: begin
                be       = addr_lo[1] ? 4'b1100 : 4'b0011;
                st_lanes = {2{st_data[15:0]}};
            end
            MEM_OP_SW: begin
                be       = 4'b1111;
                st_lanes = st_data;
            end
            MEM_OP_LB: begin
                be      = 4'b1111;
                ld_data = {{24{byte_w[7]}}, byte_w[7:0]};
            end
            MEM_OP_LBU: begin
                be      = 4'b1111;
                ld_data = {24'd0, byte_w[7:0]};
            end
            MEM_OP_LH: begin
                be      = 4'b1111;
                ld_data = {{16{half_w[15]}}, half_w};
            end
            MEM_OP_LHU: begin
                be      = 4'b1111;
                ld_data = {16'd0, half_w};
            end
            MEM_OP_LW: begin
                be      = 4'b1111;
                ld_data = ld_raw;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Pipeline MEM stage: data-bus access with misalignment checks, result mux and MEM/WB register.
// Latency: zero-wait access registers its result on the next edge; each bus wait cycle adds one.
// Backpressure: mem_busy holds the upstream pipe until dbus_ready; stall holds MEM/WB.
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  stall,
    input  logic                  flush,
    input  logic                  ex_en,
    input  logic [WORD_W-1:0]     ex_pc,
    input  logic [EXP_CODE_W-1:0] ex_exp_code,
    input  logic [MEM_OP_W-1:0]   ex_mem_op,
    input  logic [WORD_W-1:0]     ex_mem_wr_data,
    input  logic [REG_ADDR_W-1:0] ex_rd_addr,
    input  logic                  ex_gpr_we_,
    input  logic [WORD_W-1:0]     ex_out,
    input  logic [HART_ST_W-1:0]  ex_hart_st,
    output logic                  dbus_req,
    output logic                  dbus_rw,
    output logic [WORD_W-1:0]     dbus_addr,
    output logic [3:0]            dbus_be,
    output logic [WORD_W-1:0]     dbus_wr_data,
    input  logic                  dbus_ready,
    input  logic [WORD_W-1:0]     dbus_rd_data,
    output logic                  mem_busy,
    output logic [WORD_W-1:0]     fwd_data,
    output logic                  mem_en,
    output logic [WORD_W-1:0]     mem_pc,
    output logic [EXP_CODE_W-1:0] mem_exp_code,
    output logic [REG_ADDR_W-1:0] mem_rd_addr,
    output logic                  mem_gpr_we_,
    output logic [WORD_W-1:0]     mem_out,
    output logic [HART_ST_W-1:0]  mem_hart_st
);

    mem_state_e state, state_nxt;
    logic       flush_pend;
    mem_wb_t    wb_q, wb_d;

    logic              op_ld, op_st, op_mis, exp_clean;
    logic              access_valid, mis_exp, done;
    logic [3:0]        lane_be;
    logic [WORD_W-1:0] st_lanes, ld_data, result;

    assign op_ld        = is_load(ex_mem_op);
    assign op_st        = is_store(ex_mem_op);
    assign op_mis       = misaligned(ex_mem_op, ex_out[1:0]);
    assign exp_clean    = (ex_exp_code == EXP_NONE);
    assign access_valid = ex_en && exp_clean && (op_ld || op_st) && !op_mis;
    assign mis_exp      = ex_en && exp_clean && op_mis;

    mem_align u_align (
        .mem_op   (ex_mem_op),
        .addr_lo  (ex_out[1:0]),
        .st_data  (ex_mem_wr_data),
        .ld_raw   (dbus_rd_data),
        .be       (lane_be),
        .st_lanes (st_lanes),
        .ld_data  (ld_data)
    );

    // ex_* is held stable by mem_busy while waiting, so the bus fields stay stable too.
    always_comb begin
        state_nxt = state;
        dbus_req  = 1'b0;
        case (state)
            ST_IDLE: begin
                dbus_req = access_valid;
                if (access_valid && !dbus_ready) state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                dbus_req = 1'b1;
                if (dbus_ready) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
        if (reset) dbus_req = 1'b0;
    end

    assign done         = dbus_req && dbus_ready;
    assign mem_busy     = dbus_req && !dbus_ready;
    assign dbus_addr    = {ex_out[31:2], 2'b00};
    assign dbus_rw      = dbus_req && op_st;
    assign dbus_be      = dbus_req ? lane_be : 4'b0000;
    assign dbus_wr_data = (dbus_req && op_st) ? st_lanes : '0;

    assign result   = (done && op_ld) ? ld_data : ex_out;
    assign fwd_data = result;

    always_comb begin
        wb_d          = WB_BUBBLE;
        wb_d.en       = ex_en;
        wb_d.pc       = ex_pc;
        wb_d.exp_code = mis_exp ? (op_ld ? EXP_LOAD_MISALIGN : EXP_STORE_MISALIGN) : ex_exp_code;
        wb_d.rd_addr  = ex_rd_addr;
        wb_d.gpr_we_  = ex_gpr_we_ || mis_exp;
        wb_d.out      = result;
        wb_d.hart_st  = ex_hart_st;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            flush_pend <= 1'b0;
            wb_q       <= WB_BUBBLE;
        end else begin
            state <= state_nxt;
            // A flush seen mid-access must still kill the result once the bus finishes.
            if (mem_busy && flush)
                flush_pend <= 1'b1;
            else if (!mem_busy && !stall)
                flush_pend <= 1'b0;
            if (!(mem_busy || stall)) begin
                if (flush || flush_pend)
                    wb_q <= WB_BUBBLE;
                else
                    wb_q <= wb_d;
            end
        end
    end

    assign mem_en       = wb_q.en;
    assign mem_pc       = wb_q.pc;
    assign mem_exp_code = wb_q.exp_code;
    assign mem_rd_addr  = wb_q.rd_addr;
    assign mem_gpr_we_  = wb_q.gpr_we_;
    assign mem_out      = wb_q.out;
    assign mem_hart_st  = wb_q.hart_st;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: vector table for single-cycle accesses plus wait/flush/stall/reset sequences.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        reset, stall, flush;
    logic        ex_en, ex_gpr_we_;
    logic [31:0] ex_pc, ex_mem_wr_data, ex_out;
    logic [3:0]  ex_exp_code, ex_mem_op;
    logic [4:0]  ex_rd_addr;
    logic [1:0]  ex_hart_st;
    logic        dbus_req, dbus_rw, dbus_ready;
    logic [31:0] dbus_addr, dbus_wr_data, dbus_rd_data;
    logic [3:0]  dbus_be;
    logic        mem_busy, mem_en, mem_gpr_we_;
    logic [31:0] fwd_data, mem_pc, mem_out;
    logic [3:0]  mem_exp_code;
    logic [4:0]  mem_rd_addr;
    logic [1:0]  mem_hart_st;

    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mem_stage dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .ex_en(ex_en), .ex_pc(ex_pc), .ex_exp_code(ex_exp_code), .ex_mem_op(ex_mem_op),
        .ex_mem_wr_data(ex_mem_wr_data), .ex_rd_addr(ex_rd_addr), .ex_gpr_we_(ex_gpr_we_),
        .ex_out(ex_out), .ex_hart_st(ex_hart_st),
        .dbus_req(dbus_req), .dbus_rw(dbus_rw), .dbus_addr(dbus_addr), .dbus_be(dbus_be),
        .dbus_wr_data(dbus_wr_data), .dbus_ready(dbus_ready), .dbus_rd_data(dbus_rd_data),
        .mem_busy(mem_busy), .fwd_data(fwd_data),
        .mem_en(mem_en), .mem_pc(mem_pc), .mem_exp_code(mem_exp_code), .mem_rd_addr(mem_rd_addr),
        .mem_gpr_we_(mem_gpr_we_), .mem_out(mem_out), .mem_hart_st(mem_hart_st)
    );

    typedef struct {
        logic        en;
        logic [3:0]  exc;
        logic [3:0]  op;
        logic [31:0] addr;
        logic [31:0] wdat;
        logic [31:0] rdat;
        logic        rdy;
        logic        x_req;
        logic        x_rw;
        logic [3:0]  x_be;
        logic [31:0] x_wdat;
        logic        x_busy;
        logic        x_en;
        logic [3:0]  x_exc;
        logic        x_we_;
        logic [31:0] x_out;
    } vec_t;

    vec_t vecs[16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic en, input logic [3:0] exc, input logic [3:0] op,
                         input logic [31:0] addr, input logic [31:0] wdat,
                         input logic [31:0] rdat, input logic rdy);
        ex_en          = en;
        ex_exp_code    = exc;
        ex_mem_op      = op;
        ex_out         = addr;
        ex_mem_wr_data = wdat;
        dbus_rd_data   = rdat;
        dbus_ready     = rdy;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    int req_cnt, busy_cnt, drop_cnt;

    initial begin
        // en exc op addr wdat rdat rdy | req rw be wdat busy | en exc we_ out
        vecs[0]  = '{1, 0, 6, 32'h1003, 32'h000000A5, 0, 1, 1, 1, 4'b1000, 32'hA5A5A5A5, 0, 1, 0, 0, 32'h1003};
        vecs[1]  = '{1, 0, 1, 32'h2002, 0, 32'h0080FF00, 1, 1, 0, 4'b1111, 0, 0, 1, 0, 0, 32'hFFFFFF80};
        vecs[2]  = '{1, 0, 4, 32'h2002, 0, 32'h0080FF00, 1, 1, 0, 4'b1111, 0, 0, 1, 0, 0, 32'h00000080};
        vecs[3]  = '{1, 0, 2, 32'h2002, 0, 32'h80010000, 1, 1, 0, 4'b1111, 0, 0, 1, 0, 0, 32'hFFFF8001};
        vecs[4]  = '{1, 0, 5, 32'h2002, 0, 32'h80010000, 1, 1, 0, 4'b1111, 0, 0, 1, 0, 0, 32'h00008001};
        vecs[5]  = '{1, 0, 3, 32'h2000, 0, 32'hDEADBEEF, 1, 1, 0, 4'b1111, 0, 0, 1, 0, 0, 32'hDEADBEEF};
        vecs[6]  = '{1, 0, 7, 32'h1002, 32'h1234ABCD, 0, 1, 1, 1, 4'b1100, 32'hABCDABCD, 0, 1, 0, 0, 32'h1002};
        vecs[7]  = '{1, 0, 8, 32'h1000, 32'hCAFEF00D, 0, 1, 1, 1, 4'b1111, 32'hCAFEF00D, 0, 1, 0, 0, 32'h1000};
        vecs[8]  = '{1, 0, 2, 32'h4001, 0, 32'h12345678, 0, 0, 0, 4'b0000, 0, 0, 1, 4, 1, 32'h4001};
        vecs[9]  = '{1, 0, 8, 32'h4002, 32'h1, 0, 0, 0, 0, 4'b0000, 0, 0, 1, 6, 1, 32'h4002};
        vecs[10] = '{1, 0, 0, 32'h55, 0, 0, 0, 0, 0, 4'b0000, 0, 0, 1, 0, 0, 32'h55};
        vecs[11] = '{1, 2, 3, 32'h5000, 0, 32'h11111111, 0, 0, 0, 4'b0000, 0, 0, 1, 2, 0, 32'h5000};
        vecs[12] = '{1, 0, 9, 32'h66, 0, 0, 0, 0, 0, 4'b0000, 0, 0, 1, 0, 0, 32'h66};
        vecs[13] = '{0, 0, 3, 32'h7000, 0, 32'h22222222, 0, 0, 0, 4'b0000, 0, 0, 0, 0, 0, 32'h7000};
        vecs[14] = '{1, 0, 1, 32'h2001, 0, 32'h12347F56, 1, 1, 0, 4'b1111, 0, 0, 1, 0, 0, 32'h0000007F};
        vecs[15] = '{1, 0, 6, 32'h1000, 32'h1234567E, 0, 1, 1, 1, 4'b0001, 32'h7E7E7E7E, 0, 1, 0, 0, 32'h1000};

        reset = 1'b1; stall = 1'b0; flush = 1'b0;
        ex_pc = 32'h0; ex_rd_addr = 5'd3; ex_gpr_we_ = 1'b0; ex_hart_st = 2'b01;
        drive(1, 0, 3, 32'h3000, 0, 0, 0);
        #3;
        chk("rst_dbus_req", {31'd0, dbus_req}, 32'd0);
        chk("rst_mem_en", {31'd0, mem_en}, 32'd0);
        chk("rst_gpr_we_", {31'd0, mem_gpr_we_}, 32'd1);
        chk("rst_mem_out", mem_out, 32'd0);
        chk("rst_exp_code", {28'd0, mem_exp_code}, 32'd0);
        chk("rst_mem_pc", mem_pc, 32'd0);
        step();
        reset = 1'b0;

        for (int i = 0; i < 16; i++) begin
            drive(vecs[i].en, vecs[i].exc, vecs[i].op, vecs[i].addr, vecs[i].wdat,
                  vecs[i].rdat, vecs[i].rdy);
            ex_pc = 32'h100 + 32'(i);
            #3;
            chk($sformatf("v%0d_req", i), {31'd0, dbus_req}, {31'd0, vecs[i].x_req});
            chk($sformatf("v%0d_rw", i), {31'd0, dbus_rw}, {31'd0, vecs[i].x_rw});
            chk($sformatf("v%0d_be", i), {28'd0, dbus_be}, {28'd0, vecs[i].x_be});
            chk($sformatf("v%0d_wdata", i), dbus_wr_data, vecs[i].x_wdat);
            chk($sformatf("v%0d_addr", i), dbus_addr, {vecs[i].addr[31:2], 2'b00});
            chk($sformatf("v%0d_busy", i), {31'd0, mem_busy}, {31'd0, vecs[i].x_busy});
            chk($sformatf("v%0d_fwd", i), fwd_data, vecs[i].x_out);
            step();
            chk($sformatf("v%0d_mem_en", i), {31'd0, mem_en}, {31'd0, vecs[i].x_en});
            chk($sformatf("v%0d_exp", i), {28'd0, mem_exp_code}, {28'd0, vecs[i].x_exc});
            chk($sformatf("v%0d_we_", i), {31'd0, mem_gpr_we_}, {31'd0, vecs[i].x_we_});
            chk($sformatf("v%0d_out", i), mem_out, vecs[i].x_out);
            chk($sformatf("v%0d_pc", i), mem_pc, 32'h100 + 32'(i));
            chk($sformatf("v%0d_rd", i), {27'd0, mem_rd_addr}, 32'd3);
            chk($sformatf("v%0d_hart", i), {30'd0, mem_hart_st}, 32'd1);
        end

        // LW with three wait cycles.
        drive(1, 0, 0, 32'h11, 0, 0, 0);
        step();
        drive(1, 0, 3, 32'h3000, 0, 32'hA1B2C3D4, 0);
        req_cnt = 0; busy_cnt = 0;
        for (int c = 0; c < 4; c++) begin
            dbus_ready = (c == 3);
            #3;
            req_cnt  += int'(dbus_req);
            busy_cnt += int'(mem_busy);
            chk($sformatf("wait%0d_addr", c), dbus_addr, 32'h3000);
            step();
            if (c < 3) chk($sformatf("wait%0d_hold", c), mem_out, 32'h11);
        end
        chk("wait_req_cycles", 32'(req_cnt), 32'd4);
        chk("wait_busy_cycles", 32'(busy_cnt), 32'd3);
        chk("wait_result", mem_out, 32'hA1B2C3D4);
        chk("wait_mem_en", {31'd0, mem_en}, 32'd1);
        drive(0, 0, 0, 32'h0, 0, 32'hA1B2C3D4, 0);
        step();
        chk("wait_once_en", {31'd0, mem_en}, 32'd0);
        chk("wait_once_out", mem_out, 32'd0);

        // Flush pulsed while waiting: request held, result replaced by a bubble.
        drive(1, 0, 0, 32'h22, 0, 0, 0);
        step();
        drive(1, 0, 3, 32'h3004, 0, 32'h55555555, 0);
        drop_cnt = 0;
        for (int c = 0; c < 4; c++) begin
            flush      = (c == 1);
            dbus_ready = (c == 3);
            #3;
            if (!dbus_req) drop_cnt++;
            step();
        end
        flush = 1'b0;
        chk("flw_req_drops", 32'(drop_cnt), 32'd0);
        chk("flw_bubble_en", {31'd0, mem_en}, 32'd0);
        chk("flw_bubble_we_", {31'd0, mem_gpr_we_}, 32'd1);
        chk("flw_bubble_out", mem_out, 32'd0);
        drive(1, 0, 0, 32'h77, 0, 0, 0);
        step();
        chk("flw_after_en", {31'd0, mem_en}, 32'd1);
        chk("flw_after_out", mem_out, 32'h77);

        // Flush coinciding with a zero-wait access in IDLE.
        drive(1, 0, 3, 32'h3008, 0, 32'h66666666, 1);
        flush = 1'b1;
        #3;
        chk("fli_req", {31'd0, dbus_req}, 32'd1);
        chk("fli_busy", {31'd0, mem_busy}, 32'd0);
        step();
        flush = 1'b0;
        chk("fli_bubble_en", {31'd0, mem_en}, 32'd0);
        chk("fli_bubble_we_", {31'd0, mem_gpr_we_}, 32'd1);

        // Stall holds MEM/WB.
        drive(1, 0, 0, 32'h88, 0, 0, 0);
        step();
        chk("stl_pre", mem_out, 32'h88);
        drive(1, 0, 0, 32'h99, 0, 0, 0);
        stall = 1'b1;
        step();
        chk("stl_hold", mem_out, 32'h88);
        stall = 1'b0;
        step();
        chk("stl_release", mem_out, 32'h99);

        // Asynchronous reset in WAIT.
        drive(1, 0, 3, 32'h300C, 0, 32'h77777777, 0);
        step();
        #2;
        reset = 1'b1;
        #1;
        chk("arst_req", {31'd0, dbus_req}, 32'd0);
        chk("arst_mem_en", {31'd0, mem_en}, 32'd0);
        chk("arst_we_", {31'd0, mem_gpr_we_}, 32'd1);
        chk("arst_out", mem_out, 32'd0);
        step();
        reset = 1'b0;
        drive(0, 0, 0, 32'h0, 0, 0, 0);
        #3;
        chk("arst_idle_req", {31'd0, dbus_req}, 32'd0);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Params: none; widths fixed by shared defines: word 32, reg addr 5, mem_op 4, exp_code 4, hart_st 2.
REQ-002 clk  in  1  single clock; all state on rising edge.
REQ-003 reset  in  1  asynchronous, active-high.
REQ-004 stall in 1 hold MEM/WB reg; flush in 1 insert bubble into MEM/WB reg.
REQ-005 ex_en in 1; ex_pc in 32; ex_exp_code in 4; ex_mem_op in 4; ex_mem_wr_data in 32; ex_rd_addr in 5; ex_gpr_we_ in 1 (active-low); ex_out in 32 (ALU result/address); ex_hart_st in 2.
REQ-006 dbus_req out 1; dbus_rw out 1 (1=write); dbus_addr out 32 (word-aligned); dbus_be out 4; dbus_wr_data out 32; dbus_ready in 1; dbus_rd_data in 32.
REQ-007 mem_busy out 1: stall request to pipeline control; fwd_data out 32: forward value to EX.
REQ-008 mem_en out 1; mem_pc out 32; mem_exp_code out 4; mem_rd_addr out 5; mem_gpr_we_ out 1; mem_out out 32; mem_hart_st out 2 (MEM/WB register).

Function
REQ-009 mem_op codes (shared): NOP=0, LB=1, LH=2, LW=3, LBU=4, LHU=5, SB=6, SH=7, SW=8; others treated as NOP.
REQ-010 access_valid = ex_en & ex_exp_code==0 & op is load/store & aligned.
REQ-011 Misaligned: LH/LHU/SH with addr[0]=1, LW/SW with addr[1:0]!=0 -> no bus request; exp_code LOAD_MISALIGN=4 (loads) or STORE_MISALIGN=6 (stores); gpr_we_ forced 1.
REQ-012 Nonzero ex_exp_code passes through unchanged; no bus request.
REQ-013 FSM states IDLE, WAIT. IDLE: dbus_req = access_valid (combinational, same cycle); IDLE->WAIT when access_valid & ~dbus_ready; else stay.
REQ-014 WAIT: dbus_req=1 with stable addr/rw/be/data; WAIT->IDLE on dbus_ready.
REQ-015 Request, once issued, held until dbus_ready; flush never drops dbus_req.
REQ-016 Flush asserted in WAIT is latched (flush_pend); on completion the MEM/WB reg loads a bubble, not the result.
REQ-017 mem_busy = dbus_req & ~dbus_ready; upstream stalls while high, keeping ex_* stable.
REQ-018 dbus_addr = {ex_out[31:2],2'b00}; dbus_rw=1 for SB/SH/SW.
REQ-019 Stores: SB be=0001<<addr[1:0], data=byte replicated x4; SH be=0011 (addr[1]=0) or 1100, data=half replicated x2; SW be=1111, data=word.
REQ-020 Loads: be=1111; little-endian lane by addr[1:0]; LB/LH sign-extend, LBU/LHU zero-extend.
REQ-021 Result mux: completed load -> formatted data; otherwise ex_out. fwd_data = result mux, combinational.
REQ-022 MEM/WB update priority: mem_busy or stall -> hold; flush or flush_pend -> bubble (en=0, gpr_we_=1, exp_code=0, other fields 0); else load ex_* fields and result.
REQ-023 Latency: zero-wait bus completes in the issue cycle, result registered next edge; N wait cycles add N cycles.
REQ-024 Simultaneous dbus_ready and flush in IDLE: access completes on bus, MEM/WB gets bubble.

Reset
REQ-025 Reset forces state=IDLE, flush_pend=0, mem_en=0, mem_gpr_we_=1, all other MEM/WB outputs 0; dbus_req=0 while reset high.
REQ-026 Reset during WAIT abandons the transaction; bus slave also sees reset.

Structure
REQ-027 mem_op codes, exception codes, FSM state encoding live in shared defines (base_core_defines).
REQ-028 One combinational sub-module mem_align: store lane/be generation and load extraction/extension.

Verification
REQ-029 SB addr 0x1003 data 0x000000A5, ready same cycle -> be=1000, wr_data=0xA5A5A5A5, mem_busy=0, mem_en=1 next edge.
REQ-030 LB addr 0x2002, rd_data 0x0080FF00 -> mem_out=0xFFFFFF80; LBU same -> 0x00000080.
REQ-031 LW addr 0x3000, ready after 3 cycles -> dbus_req held 4 cycles, mem_busy 3 cycles, MEM/WB loads rd_data once.
REQ-032 LH addr 0x4001 -> no dbus_req, mem_exp_code=4, mem_gpr_we_=1; SW addr 0x4002 -> exp_code=6.
REQ-033 LW in WAIT, flush pulsed 1 cycle, ready 2 cycles later -> dbus_req never drops, MEM/WB bubble (en=0, gpr_we_=1).
REQ-034 Reset asserted asynchronously in WAIT -> dbus_req=0 immediately, outputs at reset values.
